// File: rtl/coin_input_ctrl.sv
// Coin sensor front end: synchronize, debounce and encode two coin lines into
// single-cycle coin codes with jam detection. Optional COIN_TOTAL_EN adds a running credit total.
module coin_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
`ifdef COIN_TOTAL_EN
  input  logic       clr_total,
  output logic [7:0] total_jiao,
`endif
  output logic [1:0] coin_code,
  output logic       jam
);

  typedef enum logic [2:0] {IDLE, DEB, EMIT, WAIT_REL, JAM} state_t;

  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] JAM_LAST = 16'(JAM_CYCLES - 1);

  state_t      state;
  logic [15:0] db_cnt, jam_cnt;
  logic        s5_m, s5, s10_m, s10;
  logic        sel_ten;
  logic        sel_hi, other_hi, any_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s5_m  <= 1'b0;
      s5    <= 1'b0;
      s10_m <= 1'b0;
      s10   <= 1'b0;
    end else begin
      s5_m  <= coin5_raw;
      s5    <= s5_m;
      s10_m <= coin10_raw;
      s10   <= s10_m;
    end
  end

  assign sel_hi   = sel_ten ? s10 : s5;
  assign other_hi = sel_ten ? s5 : s10;
  assign any_hi   = s5 | s10;

  // Reset lands in WAIT_REL so a coin held across reset must be released first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_REL;
      db_cnt    <= '0;
      jam_cnt   <= '0;
      sel_ten   <= 1'b0;
      coin_code <= 2'b00;
      jam       <= 1'b0;
    end else begin
      coin_code <= 2'b00;
      case (state)
        IDLE: begin
          if (s5 ^ s10) begin
            sel_ten <= s10;
            db_cnt  <= '0;
            state   <= DEB;
          end else if (s5 && s10) begin
            db_cnt <= '0;
            state  <= WAIT_REL;
          end
        end
        DEB: begin
          if (sel_hi && !other_hi) begin
            if (db_cnt == DEB_LAST) begin
              state     <= EMIT;
              coin_code <= sel_ten ? 2'b10 : 2'b01;
            end else begin
              db_cnt <= db_cnt + 16'd1;
            end
          end else begin
            state <= IDLE;
          end
        end
        EMIT: begin
          state   <= WAIT_REL;
          db_cnt  <= '0;
          jam_cnt <= '0;
        end
        WAIT_REL: begin
          if (!any_hi) begin
            if (db_cnt == DEB_LAST) begin
              state  <= IDLE;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + 16'd1;
            end
          end else begin
            db_cnt <= '0;
            if (jam_cnt == JAM_LAST) begin
              state <= JAM;
              jam   <= 1'b1;
            end else begin
              jam_cnt <= jam_cnt + 16'd1;
            end
          end
        end
        JAM: begin
          if (!any_hi) begin
            if (db_cnt == DEB_LAST) begin
              state  <= IDLE;
              jam    <= 1'b0;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + 16'd1;
            end
          end else begin
            db_cnt <= '0;
          end
        end
        default: state <= WAIT_REL;
      endcase
    end
  end

`ifdef COIN_TOTAL_EN
  logic [8:0] sum;
  assign sum = {1'b0, total_jiao} + (sel_ten ? 9'd10 : 9'd5);

  // Clear wins over a same-cycle credit; credit saturates at 255 jiao.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      total_jiao <= 8'd0;
    else if (clr_total)
      total_jiao <= 8'd0;
    else if (state == EMIT)
      total_jiao <= sum[8] ? 8'hFF : sum[7:0];
  end
`endif

endmodule
